fitness_time_calc: RTL and testbench
====================================

# fitness_time_calc

Parametrised, sequential exercise-duration calculator for the fitness timer. It takes raw weight, calorie target, MET and gender, and computes the minutes needed with a multi-cycle restoring divider. It adds selectable rounding, saturation and divide-by-zero reporting. The result feeds the preview and countdown path of the top level, where 2-bit and 3-bit switch codes are decoded to raw values upstream.

## Interface
Parameters:
- W_BITS, 8, weight width (kg, unsigned)
- CAL_BITS, 10, calorie-target width (kcal, unsigned)
- MET_BITS, 4, MET width (integer MET, unsigned)
- T_BITS, 8, result width (minutes)
- ROUND_UP, 1, 1 = ceiling, 0 = floor

Ports:
- clk_40MHz  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous, no asynchronous paths
- start  in  1  request pulse; sampled only when busy=0
- weight  in  W_BITS  body weight, kg
- cal  in  CAL_BITS  calorie target, kcal
- met  in  MET_BITS  activity MET
- gender  in  1  0 → factor 8/8, 1 → factor 9/8
- busy  out  1  calculation in progress
- done  out  1  one-cycle pulse when results update
- t_min  out  T_BITS  exercise time in minutes
- sat  out  1  result clipped to T_MAX
- err  out  1  denominator was zero

## Operation
- Formula: t = Cal·3200 / (7·MET·W·Gn), with Gn = 8 + gender. This is the exact integer form of Cal·200 / (3.5·MET·W·G).
- Width constants:
  - N_BITS = CAL_BITS+12; numerator N = cal·3200 fits.
  - D_BITS = W_BITS+MET_BITS+7; denominator D = 7·met·weight·Gn fits.
  - T_MAX = 2^T_BITS−1.
- States: IDLE, LOAD, DIV, FINISH.
- IDLE:
  - busy=0.
  - start=1 captures weight, cal, met and gender; go to LOAD.
  - Inputs are ignored at all other times.
- LOAD (1 cycle):
  - Register N and D, clear the quotient and remainder (remainder is D_BITS+1 bits), load bit counter = N_BITS−1.
  - Go to DIV.
- DIV (N_BITS cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - If D==0, the datapath free-runs but its result is discarded.
  - After the bit with counter==0, go to FINISH.
- FINISH (1 cycle), priority order:
  1. D==0 → t_min=T_MAX, err=1, sat=0.
  2. Otherwise q' = q + (ROUND_UP && remainder≠0).
  3. q' > T_MAX → t_min=T_MAX, sat=1, err=0.
  4. Otherwise t_min=q'[T_BITS−1:0], sat=0, err=0.
  - Pulse done=1; return to IDLE.
- cal==0 with D≠0 gives t_min=0, sat=0, err=0 (not an error).
- t_min, sat and err hold their values until the next FINISH. They do not change during a new calculation.
- start while busy=1 is dropped. It is not queued, and the calculation in flight is unaffected.

## Timing
- Reset values: busy=0, done=0, t_min=0, sat=0, err=0, state=IDLE.
- Start sampled at edge k (state IDLE):
  - busy=1 from edge k to edge k+N_BITS+1.
  - At edge k+N_BITS+2, done=1 and the outputs update, for exactly one cycle.
  - busy=0 in that same cycle.
- Latency: N_BITS+2 cycles (24 with defaults), fixed, independent of operands, error or saturation.
- A start asserted in the cycle where done=1 (busy=0) is accepted: back-to-back throughput is one result per N_BITS+2 cycles.
- Reset mid-operation: the next edge forces IDLE and all outputs to their reset values. The aborted calculation never raises done.
- reset and start in the same cycle: reset wins and start is ignored.

## Test plan
1. W=70, Cal=100, MET=4, gender=0, ROUND_UP=1 → D=15680; done 24 cycles after start; t_min=21, sat=0, err=0. Same operands with ROUND_UP=0 → t_min=20.
2. W=70, Cal=100, MET=4, gender=1 → t_min=19. Then W=60, Cal=100, MET=2, gender=0 → t_min=48. Both give busy=1 for exactly 23 cycles.
3. Exact quotient: W=50, Cal=7, MET=1, gender=0 → t_min=8 in both rounding modes. Cal=0 → t_min=0, err=0.
4. Saturation: W=50, Cal=1000, MET=1, gender=0 (true 1142.9) → t_min=255, sat=1. MET=0 → t_min=255, err=1, sat=0, same latency.
5. Handshake:
   - Pulse start again 5 cycles after an accepted start with different operands → ignored; result equals the first request.
   - start in the done cycle → second result after a further 24 cycles.
6. Reset asserted 10 cycles into a calculation → next cycle busy=0, t_min=0, sat=0, err=0; no done pulse. reset+start together → no calculation starts.

Source files
------------

// File: rtl/fitness_time_calc.sv
// Exercise-duration calculator: t = cal*3200 / (7*met*weight*(8+gender)),
// evaluated by a restoring divider with rounding, saturation and zero-divide flags.
module fitness_time_calc #(
  parameter int unsigned W_BITS   = 8,
  parameter int unsigned CAL_BITS = 10,
  parameter int unsigned MET_BITS = 4,
  parameter int unsigned T_BITS   = 8,
  parameter int unsigned ROUND_UP = 1
) (
  input  logic                clk_40MHz,
  input  logic                reset,
  input  logic                start,
  input  logic [W_BITS-1:0]   weight,
  input  logic [CAL_BITS-1:0] cal,
  input  logic [MET_BITS-1:0] met,
  input  logic                gender,
  output logic                busy,
  output logic                done,
  output logic [T_BITS-1:0]   t_min,
  output logic                sat,
  output logic                err
);

  localparam int unsigned N_BITS   = CAL_BITS + 12;
  localparam int unsigned D_BITS   = W_BITS + MET_BITS + 7;
  localparam int unsigned R_BITS   = D_BITS + 1;
  localparam int unsigned Q1_BITS  = N_BITS + 1;
  localparam int unsigned CNT_BITS = $clog2(N_BITS);
  localparam logic [T_BITS-1:0] T_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [W_BITS-1:0]    weight_q, weight_d;
  logic [CAL_BITS-1:0]  cal_q, cal_d;
  logic [MET_BITS-1:0]  met_q, met_d;
  logic                 gender_q, gender_d;
  logic [N_BITS-1:0]    n_q, n_d;
  logic [D_BITS-1:0]    d_q, d_d;
  logic [N_BITS-1:0]    q_q, q_d;
  logic [R_BITS-1:0]    rem_q, rem_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [T_BITS-1:0]    t_min_q, t_min_d;
  logic                 sat_q, sat_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [R_BITS-1:0]    rem_shift;
  logic [R_BITS-1:0]    rem_sub;
  logic [3:0]           gn;
  logic                 round_inc;
  logic [Q1_BITS-1:0]   q_round;

  always_comb begin
    state_d   = state_q;
    weight_d  = weight_q;
    cal_d     = cal_q;
    met_d     = met_q;
    gender_d  = gender_q;
    n_d       = n_q;
    d_d       = d_q;
    q_d       = q_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    t_min_d   = t_min_q;
    sat_d     = sat_q;
    err_d     = err_q;
    done_d    = 1'b0;

    gn        = gender_q ? 4'd9 : 4'd8;
    rem_shift = {rem_q[D_BITS-1:0], n_q[N_BITS-1]};
    rem_sub   = rem_shift - {1'b0, d_q};
    round_inc = (ROUND_UP != 0) && (rem_q != '0);
    q_round   = {1'b0, q_q} + Q1_BITS'(round_inc);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          weight_d = weight;
          cal_d    = cal;
          met_d    = met;
          gender_d = gender;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        n_d     = N_BITS'(cal_q) * N_BITS'(12'd3200);
        d_d     = D_BITS'(weight_q) * D_BITS'(met_q) * D_BITS'(gn) * D_BITS'(3'd7);
        q_d     = '0;
        rem_d   = '0;
        cnt_d   = CNT_BITS'(N_BITS - 1);
        state_d = S_DIV;
      end
      S_DIV: begin
        // Numerator is consumed MSB-first by shifting it out of n_q.
        if (rem_shift >= {1'b0, d_q}) begin
          rem_d = rem_sub;
          q_d   = {q_q[N_BITS-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          q_d   = {q_q[N_BITS-2:0], 1'b0};
        end
        n_d = {n_q[N_BITS-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (d_q == '0) begin
          t_min_d = T_MAX;
          err_d   = 1'b1;
          sat_d   = 1'b0;
        end else if (q_round > Q1_BITS'(T_MAX)) begin
          t_min_d = T_MAX;
          sat_d   = 1'b1;
          err_d   = 1'b0;
        end else begin
          t_min_d = q_round[T_BITS-1:0];
          sat_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      weight_q <= '0;
      cal_q    <= '0;
      met_q    <= '0;
      gender_q <= 1'b0;
      n_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      t_min_q  <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      cal_q    <= cal_d;
      met_q    <= met_d;
      gender_q <= gender_d;
      n_q      <= n_d;
      d_q      <= d_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      t_min_q  <= t_min_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // FINISH is the result-write cycle; busy covers only LOAD and DIV.
  assign busy  = (state_q == S_LOAD) || (state_q == S_DIV);
  assign done  = done_q;
  assign t_min = t_min_q;
  assign sat   = sat_q;
  assign err   = err_q;

endmodule

// File: tb/tb_fitness_time_calc.sv
// Directed bench for fitness_time_calc: ceiling and floor instances share stimulus.
`timescale 1ns/1ps
module tb_fitness_time_calc;

  logic       clk_40MHz = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] weight;
  logic [9:0] cal;
  logic [3:0] met;
  logic       gender;

  logic       busy_up, done_up, sat_up, err_up;
  logic [7:0] t_up;
  logic       busy_dn, done_dn, sat_dn, err_dn;
  logic [7:0] t_dn;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #12.5 clk_40MHz = ~clk_40MHz;

  fitness_time_calc #(.W_BITS(8), .CAL_BITS(10), .MET_BITS(4), .T_BITS(8), .ROUND_UP(1)) dut_up (
    .clk_40MHz(clk_40MHz), .reset(reset), .start(start), .weight(weight), .cal(cal),
    .met(met), .gender(gender), .busy(busy_up), .done(done_up), .t_min(t_up),
    .sat(sat_up), .err(err_up)
  );

  fitness_time_calc #(.W_BITS(8), .CAL_BITS(10), .MET_BITS(4), .T_BITS(8), .ROUND_UP(0)) dut_dn (
    .clk_40MHz(clk_40MHz), .reset(reset), .start(start), .weight(weight), .cal(cal),
    .met(met), .gender(gender), .busy(busy_dn), .done(done_dn), .t_min(t_dn),
    .sat(sat_dn), .err(err_dn)
  );

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  // Launch one calculation and check latency, busy width, held outputs and result.
  // A nonzero spur_at pulses start with other operands at that edge offset.
  task automatic run_calc(input string name, input logic [7:0] w, input logic [9:0] c,
                          input logic [3:0] m, input logic g,
                          input logic [7:0] exp_up, input logic [7:0] exp_dn,
                          input logic exp_sat, input logic exp_err, input int spur_at);
    int done_at = -1;
    int busy_n  = 0;
    logic [7:0] prev_t = t_up;
    weight = w; cal = c; met = m; gender = g; start = 1'b1;
    tick();
    start = 1'b0;
    if (busy_up) busy_n++;
    for (int i = 1; i <= 40; i++) begin
      if (i == spur_at) begin
        weight = 8'd1; cal = 10'd1000; met = 4'd1; gender = 1'b1; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (i == 10) begin
        total_cnt++;
        if (t_up !== prev_t) $display("FAIL %s_hold: t_min=%0d expected %0d", name, t_up, prev_t);
        else pass_cnt++;
      end
      if (done_up) begin
        done_at = i;
        break;
      end
      if (busy_up) busy_n++;
    end
    total_cnt++;
    if (done_at !== 24) $display("FAIL %s_latency: done at %0d expected 24", name, done_at);
    else pass_cnt++;
    total_cnt++;
    if (busy_n !== 23) $display("FAIL %s_busy: busy cycles %0d expected 23", name, busy_n);
    else pass_cnt++;
    total_cnt++;
    if (busy_up !== 1'b0 || done_dn !== 1'b1)
      $display("FAIL %s_done_cycle: busy=%b done_dn=%b expected busy=0 done_dn=1", name, busy_up, done_dn);
    else pass_cnt++;
    total_cnt++;
    if (t_up !== exp_up || sat_up !== exp_sat || err_up !== exp_err)
      $display("FAIL %s_ceil: t=%0d sat=%b err=%b expected t=%0d sat=%b err=%b",
               name, t_up, sat_up, err_up, exp_up, exp_sat, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (t_dn !== exp_dn || sat_dn !== exp_sat || err_dn !== exp_err)
      $display("FAIL %s_floor: t=%0d sat=%b err=%b expected t=%0d sat=%b err=%b",
               name, t_dn, sat_dn, err_dn, exp_dn, exp_sat, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; weight = '0; cal = '0; met = '0; gender = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if (busy_up !== 1'b0 || done_up !== 1'b0 || t_up !== 8'd0 || sat_up !== 1'b0 || err_up !== 1'b0)
      $display("FAIL reset: busy=%b done=%b t=%0d sat=%b err=%b expected all zero",
               busy_up, done_up, t_up, sat_up, err_up);
    else pass_cnt++;
  endtask

  task automatic test_rounding();
    // D=15680, 320000/D = 20.41
    run_calc("round", 8'd70, 10'd100, 4'd4, 1'b0, 8'd21, 8'd20, 1'b0, 1'b0, 0);
    tick();
    total_cnt++;
    if (done_up !== 1'b0) $display("FAIL done_pulse: done=%b expected 0", done_up);
    else pass_cnt++;
  endtask

  task automatic test_gender();
    // D=17640 -> 18.14; D=6720 -> 47.62
    run_calc("gender1", 8'd70, 10'd100, 4'd4, 1'b1, 8'd19, 8'd18, 1'b0, 1'b0, 0);
    run_calc("met2", 8'd60, 10'd100, 4'd2, 1'b0, 8'd48, 8'd47, 1'b0, 1'b0, 0);
  endtask

  task automatic test_exact();
    run_calc("exact", 8'd50, 10'd7, 4'd1, 1'b0, 8'd8, 8'd8, 1'b0, 1'b0, 0);
    run_calc("cal0", 8'd50, 10'd0, 4'd1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_saturation();
    run_calc("sat", 8'd50, 10'd1000, 4'd1, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0, 0);
    run_calc("div0", 8'd50, 10'd100, 4'd0, 1'b0, 8'd255, 8'd255, 1'b0, 1'b1, 0);
  endtask

  task automatic test_ignore_busy_start();
    run_calc("ignore", 8'd70, 10'd100, 4'd4, 1'b0, 8'd21, 8'd20, 1'b0, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    run_calc("b2b_a", 8'd70, 10'd100, 4'd4, 1'b1, 8'd19, 8'd18, 1'b0, 1'b0, 0);
    run_calc("b2b_b", 8'd60, 10'd100, 4'd2, 1'b0, 8'd48, 8'd47, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_abort();
    bit saw_done = 1'b0;
    bit saw_busy = 1'b0;
    weight = 8'd70; cal = 10'd100; met = 4'd4; gender = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (busy_up !== 1'b0 || t_up !== 8'd0 || sat_up !== 1'b0 || err_up !== 1'b0)
      $display("FAIL abort_reset: busy=%b t=%0d sat=%b err=%b expected 0 0 0 0",
               busy_up, t_up, sat_up, err_up);
    else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_up) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: done seen=%b expected 0", saw_done);
    else pass_cnt++;
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy_up) saw_busy = 1'b1;
      if (done_up) saw_done = 1'b1;
      tick();
    end
    total_cnt++;
    if (saw_busy !== 1'b0 || saw_done !== 1'b0)
      $display("FAIL reset_start: busy seen=%b done seen=%b expected 0 0", saw_busy, saw_done);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_gender();
    test_exact();
    test_saturation();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
